f_fetch_ctrl: RTL and testbench
===============================

Name: f_fetch_ctrl

Overview:
- Sequences the F stage of the P5 pipelined MIPS core.
- Owns next-PC selection, the PC write enable into f_ifu, the F/D pipeline register enable/clear, and the end-of-program halt/drain sequence.
- Sits between f_ifu (PC register plus instruction memory), the hazard unit (stall), and the D-stage branch/jump resolver.
- Also keeps a fetch counter for the bench and for performance checks.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- DRAIN_CYCLES, 4, cycles to wait after halt so the instructions behind the halt (D, E, M, W) retire; minimum 1.
- CNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- pc  in  32  current PC from f_ifu.
- stall  in  1  hazard-unit stall request (freeze F and F/D).
- br_taken  in  1  D-stage redirect valid (branch taken, j, jal, jr).
- br_target  in  32  D-stage redirect address.
- halt_req  in  1  D stage holds a halt-class instruction.
- pc_we  out  1  write enable for f_ifu PC register.
- nPc  out  32  next PC for f_ifu.
- halt  out  1  freeze to f_ifu.
- fd_en  out  1  F/D register enable.
- fd_clr  out  1  F/D register synchronous clear (bubble insert).
- done  out  1  pipeline drained, program finished (registered).
- fetch_count  out  CNT_W  instructions accepted into F/D (registered).
- state  out  2  FSM state, debug.

Behaviour:
- States: BOOT=0, RUN=1, DRAIN=2, HALTED=3.
- Registered: state, drain counter, done, fetch_count. All other outputs are combinational from state and inputs.
- While reset_n=0 at a posedge:
  - registers go to state=BOOT, done=0, fetch_count=0, drain cnt=0;
  - combinational outputs show BOOT values (pc_we=1, nPc=RESET_PC, fd_clr=1, fd_en=1, halt=0).
- BOOT (one cycle):
  - pc_we=1, nPc=RESET_PC, fd_clr=1; stall and br_taken ignored.
  - Next state RUN, so the first instruction at RESET_PC reaches D two cycles after reset is released.
- RUN:
  - nPc priority: halt_req -> pc; else br_taken -> {br_target[31:2],2'b00}; else pc+4 (mod 2^32, wraps silently).
  - pc_we = fd_en = ~stall; halt=0; fd_clr=0 (see the Optional Feature section).
  - fetch_count += 1 on each posedge where ~stall & ~halt_req.
- Simultaneous events:
  - stall=1: PC and F/D frozen; br_taken and halt_req are not acted on; D re-presents them next cycle.
  - halt_req=1 and ~stall: pc_we=0, fd_clr=1 (the F-stage instruction becomes a bubble); next state DRAIN with cnt=DRAIN_CYCLES-1. Halt outranks a redirect in the same cycle.
- DRAIN:
  - halt=1, pc_we=0, fd_en=1, fd_clr=1; stall and br_taken ignored.
  - cnt decrements each cycle; at cnt==0 next state is HALTED.
- HALTED:
  - halt=1, pc_we=0, fd_clr=1, done=1 (set on entry edge).
  - Left only through reset.
- fetch_count saturates at all-ones; it does not wrap.
- Reset asserted mid-DRAIN or in HALTED: next edge goes to BOOT, done clears, count clears.

Optional Feature:
- Macro: FETCH_NO_DELAY_SLOT_EN.
- Undefined (default): MIPS delay-slot semantics. A redirect does not clear F/D, so the instruction after the branch executes.
- Defined: in RUN with br_taken & ~stall & ~halt_req, fd_clr=1 (delay-slot instruction squashed) and fetch_count is not incremented that cycle.

Decomposition:
- Shared package/header holds:
  - state encodings F_BOOT/F_RUN/F_DRAIN/F_HALTED;
  - the default RESET_PC 32'h0000_3000;
  - the INSTR_BYTES=4 constant.
- One natural sub-module: f_npc_sel, the combinational next-PC mux (halt/redirect/sequential, word alignment).
- FSM, drain counter and fetch counter stay in f_fetch_ctrl.

Test Plan:
- Reset then release, no stall, 5 cycles:
  - nPc = 0x3000, 0x3004, 0x3008, 0x300C, ...
  - fetch_count=4 after the fourth RUN edge.
- RUN at pc=0x3010, stall=1 for 3 cycles:
  - pc_we=0, fd_en=0 throughout, nPc steady at 0x3014, fetch_count unchanged.
  - On release the PC advances to 0x3014.
- pc=0x3020, br_taken=1, br_target=0x3102:
  - nPc=0x3100, fd_clr=0.
  - With FETCH_NO_DELAY_SLOT_EN defined: fd_clr=1 and the count is not incremented.
- br_taken=1 together with stall=1 for 2 cycles, then stall=0: the redirect is applied only on the third cycle.
- halt_req=1 (and br_taken=1) at pc=0x3040, DRAIN_CYCLES=4:
  - nPc=0x3040, pc_we=0.
  - State goes DRAIN for 4 cycles, then HALTED with done=1 and halt=1.
  - Further inputs are ignored.
- reset_n=0 for one edge during DRAIN: state=BOOT, done=0, fetch_count=0; the next fetch is 0x3000.

Source files
------------

// File: rtl/f_fetch_ctrl_pkg.sv
// Shared definitions for the P5 F-stage fetch controller: state encodings,
// default boot address and instruction size.
package f_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    F_BOOT   = 2'd0,
    F_RUN    = 2'd1,
    F_DRAIN  = 2'd2,
    F_HALTED = 2'd3
  } f_state_e;

  localparam logic [31:0] F_RESET_PC  = 32'h0000_3000;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/f_npc_sel.sv
// Next-PC mux for the F stage: a halt holds the current PC, a redirect
// takes the word-aligned target, otherwise fetch falls through sequentially.
module f_npc_sel
  import f_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        halt_req_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] npc_o
);

  logic [1:0] unused_tgt_lo;
  assign unused_tgt_lo = br_target_i[1:0];

  always_comb begin
    npc_o = pc_i + 32'(INSTR_BYTES);
    if (halt_req_i)      npc_o = pc_i;
    else if (br_taken_i) npc_o = {br_target_i[31:2], 2'b00};
  end

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage sequencer: boot, run, post-halt drain and halted states, PC/F-D
// control and a saturating fetch counter. Define FETCH_NO_DELAY_SLOT_EN to
// squash the delay-slot instruction behind a taken redirect.
module f_fetch_ctrl
  import f_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = F_RESET_PC,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             halt_req_i,
  output logic             pc_we_o,
  output logic [31:0]      nPc_o,
  output logic             halt_o,
  output logic             fd_en_o,
  output logic             fd_clr_o,
  output logic             done_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [1:0]       state_o
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  f_state_e         state_q, state_d, st_eff;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [31:0]      sel_npc;
  logic             redirect_sq;

  f_npc_sel u_npc_sel (
    .pc_i        (pc_i),
    .halt_req_i  (halt_req_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .npc_o       (sel_npc)
  );

  // While reset is held the outputs already present the boot values.
  assign st_eff = reset_n_i ? state_q : F_BOOT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    pc_we_o     = 1'b0;
    nPc_o       = pc_i;
    halt_o      = 1'b1;
    fd_en_o     = 1'b1;
    fd_clr_o    = 1'b1;
    redirect_sq = 1'b0;
`ifdef FETCH_NO_DELAY_SLOT_EN
    redirect_sq = br_taken_i & ~halt_req_i;
`endif
    unique case (st_eff)
      F_BOOT: begin
        pc_we_o = 1'b1;
        nPc_o   = RESET_PC;
        halt_o  = 1'b0;
        state_d = F_RUN;
      end
      F_RUN: begin
        nPc_o    = sel_npc;
        halt_o   = 1'b0;
        fd_en_o  = ~stall_i;
        pc_we_o  = ~stall_i & ~halt_req_i;
        fd_clr_o = ~stall_i & (halt_req_i | redirect_sq);
        if (!stall_i) begin
          if (halt_req_i) begin
            state_d = F_DRAIN;
            cnt_d   = DW'(DRAIN_CYCLES - 1);
          end else if (!redirect_sq && fcnt_q != '1) begin
            fcnt_d = fcnt_q + CNT_W'(1);
          end
        end
      end
      F_DRAIN: begin
        if (cnt_q == '0) state_d = F_HALTED;
        else             cnt_d   = cnt_q - DW'(1);
      end
      default: ;
    endcase
    done_d = (state_d == F_HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= F_BOOT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign done_o        = done_q;
  assign fetch_count_o = fcnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: a cycle model plus f_ifu PC register in
// the bench, checked every negedge, plus hand-computed literal expectations.
module tb_f_fetch_ctrl;

  localparam int    DRAIN = 4;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX3  = 7;
`ifdef FETCH_NO_DELAY_SLOT_EN
  localparam bit NDS = 1'b1;
`else
  localparam bit NDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_r = 32'h0;
  logic        stall = 1'b0, br = 1'b0, hreq = 1'b0;
  logic [31:0] tgt = 32'h0;

  logic        pc_we, halt, fd_en, fd_clr, done, s_pc_we, s_halt, s_fd_en, s_fd_clr, s_done;
  logic [31:0] npc, s_npc;
  logic [31:0] fcnt;
  logic [2:0]  s_fcnt;
  logic [1:0]  state, s_state;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  f_fetch_ctrl #(.RESET_PC(32'h0000_3000), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .pc_i(pc_r), .stall_i(stall), .br_taken_i(br),
    .br_target_i(tgt), .halt_req_i(hreq), .pc_we_o(pc_we), .nPc_o(npc), .halt_o(halt),
    .fd_en_o(fd_en), .fd_clr_o(fd_clr), .done_o(done), .fetch_count_o(fcnt), .state_o(state)
  );

  // Narrow counter copy to reach saturation within a short run.
  f_fetch_ctrl #(.RESET_PC(32'h0000_3000), .DRAIN_CYCLES(DRAIN), .CNT_W(3)) u_sat (
    .clk_i(clk), .reset_n_i(rst_n), .pc_i(pc_r), .stall_i(stall), .br_taken_i(br),
    .br_target_i(tgt), .halt_req_i(hreq), .pc_we_o(s_pc_we), .nPc_o(s_npc), .halt_o(s_halt),
    .fd_en_o(s_fd_en), .fd_clr_o(s_fd_clr), .done_o(s_done), .fetch_count_o(s_fcnt), .state_o(s_state)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit pc_we, fd_en, fd_clr, halt, npc_chk;
    logic [31:0] npc;
  } exp_t;

  int     m_mode = 0;     // 0 boot, 1 run, 2 drain, 3 halted
  int     m_age  = 0;     // cycles already spent draining
  bit     m_done = 0;
  longint m_cnt  = 0, m_cnt3 = 0;

  function automatic exp_t expect_now();
    exp_t e;
    e = '{pc_we: 0, fd_en: 1, fd_clr: 1, halt: 1, npc_chk: 0, npc: 32'h0};
    if (!rst_n || m_mode == 0) begin
      e = '{pc_we: 1, fd_en: 1, fd_clr: 1, halt: 0, npc_chk: 1, npc: 32'h0000_3000};
    end else if (m_mode == 1) begin
      e.halt = 0; e.npc_chk = 1;
      e.fd_en = !stall;
      e.pc_we = !stall && !hreq;
      e.fd_clr = !stall && (hreq || (NDS && br));
      if (hreq)    e.npc = pc_r;
      else if (br) e.npc = tgt & 32'hFFFF_FFFC;
      else         e.npc = pc_r + 32'd4;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = expect_now();
    if (e.pc_we) pc_r <= e.npc;
    if (!rst_n) begin
      m_mode <= 0; m_done <= 0; m_cnt <= 0; m_cnt3 <= 0; m_age <= 0;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (m_mode == 1 && !stall) begin
      if (hreq) begin
        m_mode <= 2; m_age <= 0;
      end else if (!(NDS && br)) begin
        if (m_cnt  < MAX32) m_cnt  <= m_cnt + 1;
        if (m_cnt3 < MAX3)  m_cnt3 <= m_cnt3 + 1;
      end
    end else if (m_mode == 2) begin
      if (m_age + 1 == DRAIN) begin m_mode <= 3; m_done <= 1; end
      else m_age <= m_age + 1;
    end
    chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = expect_now();
      chk("m.state", state, m_mode);
      chk("m.done", done, m_done);
      chk("m.fetch_count", fcnt, m_cnt);
      chk("m.sat_count", s_fcnt, m_cnt3);
      chk("m.pc_we", pc_we, e.pc_we);
      chk("m.fd_en", fd_en, e.fd_en);
      chk("m.fd_clr", fd_clr, e.fd_clr);
      chk("m.halt", halt, e.halt);
      if (e.npc_chk) chk("m.nPc", npc, e.npc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit s, input bit b, input logic [31:0] t, input bit h);
    stall = s; br = b; tgt = t; hreq = h;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    tick(); tick();
    chk("rst.state", state, 0);
    chk("rst.done", done, 0);
    chk("rst.count", fcnt, 0);
    chk("rst.nPc", npc, 32'h3000);
    chk("rst.fd_clr", fd_clr, 1);
    rst_n = 1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("seq.nPc", npc, 32'h3000 + 32'(4 * i));
      tick();
    end
    chk("seq.count", fcnt, 4);
    chk("seq.pc", pc_r, 32'h3010);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.pc_we", pc_we, 0);
      chk("stall.fd_en", fd_en, 0);
      chk("stall.nPc", npc, 32'h3014);
      chk("stall.count", fcnt, 4);
      tick();
    end
    drive(0, 0, 0, 0); #1;
    chk("unstall.pc_we", pc_we, 1);
    tick();
    chk("unstall.pc", pc_r, 32'h3014);
    chk("unstall.count", fcnt, 5);
    tick(); tick(); tick();
    chk("run.pc", pc_r, 32'h3020);
    chk("run.count", fcnt, 8);
    chk("sat.count", s_fcnt, 7);

    drive(0, 1, 32'h3102, 0); #1;
    chk("br.nPc", npc, 32'h3100);
    chk("br.fd_clr", fd_clr, NDS);
    tick();
    chk("br.pc", pc_r, 32'h3100);
    chk("br.count", fcnt, NDS ? 8 : 9);

    drive(1, 1, 32'h3042, 0); #1;
    chk("brst.pc_we", pc_we, 0);
    tick(); tick();
    chk("brst.pc", pc_r, 32'h3100);
    drive(0, 1, 32'h3042, 0); #1;
    chk("brst.nPc", npc, 32'h3040);
    tick();
    chk("brst.pc2", pc_r, 32'h3040);
    chk("brst.count", fcnt, NDS ? 8 : 10);

    drive(0, 1, 32'h3300, 1); #1;
    chk("halt.nPc", npc, 32'h3040);
    chk("halt.pc_we", pc_we, 0);
    chk("halt.fd_clr", fd_clr, 1);
    tick();
    drive(1, 1, 32'h5000, 1);
    for (int i = 0; i < DRAIN; i++) begin
      chk("drain.state", state, 2);
      chk("drain.halt", halt, 1);
      chk("drain.done", done, 0);
      tick();
    end
    chk("halted.state", state, 3);
    chk("halted.done", done, 1);
    chk("halted.halt", halt, 1);
    drive(0, 1, 32'h6000, 0);
    tick(); tick();
    chk("halted.state2", state, 3);
    chk("halted.pc", pc_r, 32'h3040);

    rst_n = 0; tick();
    rst_n = 1; drive(0, 0, 0, 0);
    tick(); tick(); tick();
    chk("rerun.count", fcnt, 2);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0); tick();
    chk("rerun.state", state, 2);
    rst_n = 0; tick();
    chk("midrst.state", state, 0);
    chk("midrst.done", done, 0);
    chk("midrst.count", fcnt, 0);
    chk("midrst.nPc", npc, 32'h3000);
    rst_n = 1; tick();
    chk("midrst.pc", pc_r, 32'h3000);
    chk("midrst.nPc2", npc, 32'h3004);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
